simple_rx_chk: RTL
==================

# simple_rx_chk

Receive-side packet checker that sits directly downstream of `simple_tx` on the loopback path, consuming its 64-bit AXI-Stream generator output. For each packet it checks length, byte strobes and the generator's payload pattern, and tracks packet sequence. It keeps saturating good/bad/error counters for the register block. It is also the throttled sink for backpressure testing of the transmit side.

## Interface
Parameters:
- `C_S_AXIS_DATA_WIDTH`, 64: stream width. Only 64 is supported.
- `C_CHK_PKT_SIZE`, 16: expected packet length in words, legal range 2..65535.
- `C_CNT_WIDTH`, 32: width of each statistics counter.
- `C_BP_PERIOD`, 0: `tready` is deasserted for one cycle in every `C_BP_PERIOD` cycles. 0 means no throttling.

Ports:
- `axi_aclk`, in, 1: the single clock.
- `axi_areset`, in, 1: synchronous, active-high reset.
- `s_axis_tdata`, in, 64: stream data.
- `s_axis_tstrb`, in, 8: byte strobes.
- `s_axis_tvalid`, in, 1: beat valid.
- `s_axis_tready`, out, 1: checker accepts the beat.
- `s_axis_tlast`, in, 1: last beat of the packet.
- `chk_enable`, in, 1: enables the checker. While it is 0, `tready` is 0.
- `clear_counters`, in, 1: single-cycle pulse that zeroes all counters and drops sequence lock.
- `good_pkt_cnt`, out, C_CNT_WIDTH: count of good packets.
- `bad_pkt_cnt`, out, C_CNT_WIDTH: count of bad packets.
- `word_err_cnt`, out, C_CNT_WIDTH: count of mismatching words.
- `seq_err_cnt`, out, C_CNT_WIDTH: count of sequence errors.
- `err_pulse`, out, 1: one-cycle pulse when a bad packet is closed.
- `locked`, out, 1: sequence lock acquired.

## Operation
- A beat is accepted when `s_axis_tvalid && s_axis_tready`.
- Expected payload for word i (0-based) of packet with sequence number s: `{s[31:0], i[31:0]}`. `tstrb` must be 8'hFF on every word.
- State `S_IDLE`: the first accepted beat is word 0.
  - If that beat has `tlast`, the packet is short: count it bad and stay in `S_IDLE`.
  - Otherwise go to `S_PKT`.
- State `S_PKT`: the word index increments on each accepted beat.
  - `tlast` at index C_CHK_PKT_SIZE-1 closes the packet; go to `S_IDLE`.
  - `tlast` earlier than that is a short packet: bad; go to `S_IDLE`.
  - Index C_CHK_PKT_SIZE-1 without `tlast` is a long packet: bad; go to `S_DRAIN`.
- State `S_DRAIN`: accept beats without checking them until `tlast`, then go to `S_IDLE`. The packet was already counted bad when `S_DRAIN` was entered; it is not counted again.
- Word check: a mismatch in `tdata[31:0]` (index) or in `tstrb` increments `word_err_cnt` by 1 per word and marks the packet bad.
- Sequence check on word 0 only:
  - Unlocked: take s from `tdata[63:32]`, set `locked`, and set expected = s+1. This is never an error.
  - Locked: compare `tdata[63:32]` with expected. On mismatch, increment `seq_err_cnt`, mark the packet bad, and resync expected = received+1.
  - Words 1..N-1 must carry the same s as word 0; a mismatch is a word error.
  - Expected sequence wraps modulo 2^32 with no error.
- Packet close: a packet is good only if its length is exact and it had no word error and no sequence error; otherwise it is bad.
- All counters saturate at all-ones.
- `clear_counters` takes priority over any same-cycle increment: counters go to 0 and `locked` goes to 0. It does not change the FSM state.
- Backpressure: a free-running counter from 0 to C_BP_PERIOD-1 forces `tready` to 0 when it reaches C_BP_PERIOD-1. AXIS rules apply; `tvalid` and data are held by the source.
- `chk_enable` falling mid-packet: `tready` goes to 0 and all state is kept; checking resumes when it returns to 1.

## Timing
- Reset values:
  - `s_axis_tready` = 0.
  - All counters = 0.
  - `err_pulse` = 0.
  - `locked` = 0.
  - FSM = `S_IDLE`; word index = 0; BP counter = 0.
- `s_axis_tready` is registered. It is 1 from the first cycle after reset deassertion (if `chk_enable`), except for throttle cycles.
- `word_err_cnt` updates in the cycle after the bad word is accepted.
- `seq_err_cnt` updates in the cycle after word 0 is accepted.
- `good_pkt_cnt` / `bad_pkt_cnt` and `err_pulse` appear in the cycle after the closing beat. For a long packet, the closing beat is the beat at index N-1.
- Full throughput: back-to-back packets with no idle cycle between `tlast` and the next word 0 are accepted.
- Reset mid-packet: the partial packet is discarded without counting; the next accepted beat is treated as word 0.

## Structure
- Shared package `simple_pkt_pkg` holds:
  - the FSM state enum (`S_IDLE`, `S_PKT`, `S_DRAIN`);
  - the payload-word constructor function `{seq, idx}`;
  - the all-ones strobe constant.
  
  `simple_tx` uses the same package.
- One sub-module, `sat_counter` (parameterised width, `inc`, `clr`, `clr` has priority), instantiated four times.

## Test plan
- 3 correct 16-word packets, seq 0,1,2, no BP → good=3, bad=0, `locked`=1; all accepted in 48 consecutive cycles.
- 10-word packet with `tlast` on word 9 → bad=1, one `err_pulse`, FSM in `S_IDLE`; following 16-word packet → good=1.
- 20-word packet → bad=1 counted one cycle after word 15; words 16-19 drained; no extra counts.
- Packet seq 5 then seq 7 → seq_err=1, bad=1; next seq 8 → good.
- Word 3 with idx=99 and word 4 with `tstrb`=8'h0F → word_err=2, bad=1.
- `C_BP_PERIOD`=4, 4 packets → `tready` low every 4th cycle, good=4. `clear_counters` asserted together with a closing beat → all counters read 0, `locked`=0.

Source files
------------

// File: rtl/simple_pkt_pkg.sv
// Types and helpers shared by the simple_tx generator and the simple_rx_chk checker.
package simple_pkt_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PKT   = 2'd1,
    S_DRAIN = 2'd2
  } pkt_state_t;

  localparam logic [7:0] STRB_ALL = 8'hFF;

  // Payload word i of packet s carries the sequence number in the upper half.
  function automatic logic [63:0] mk_word(input logic [31:0] seq, input logic [31:0] idx);
    return {seq, idx};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/simple_rx_chk.sv
// Loopback receive checker for the simple_tx stream: validates length, strobes,
// payload pattern and sequence, and keeps saturating statistics.
module simple_rx_chk
  import simple_pkt_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_CHK_PKT_SIZE      = 16,
  parameter int C_CNT_WIDTH         = 32,
  parameter int C_BP_PERIOD         = 0
) (
  input  logic                             axi_aclk,
  input  logic                             axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic                             chk_enable,
  input  logic                             clear_counters,
  output logic [C_CNT_WIDTH-1:0]           good_pkt_cnt,
  output logic [C_CNT_WIDTH-1:0]           bad_pkt_cnt,
  output logic [C_CNT_WIDTH-1:0]           word_err_cnt,
  output logic [C_CNT_WIDTH-1:0]           seq_err_cnt,
  output logic                             err_pulse,
  output logic                             locked
);

  localparam logic [31:0] LAST_IDX = 32'(C_CHK_PKT_SIZE - 1);
  localparam int BPW = (C_BP_PERIOD > 1) ? $clog2(C_BP_PERIOD) : 1;

  pkt_state_t     r_state, w_state_nxt;
  logic [31:0]    r_idx, w_idx_nxt;
  logic           r_bad, w_bad_nxt;
  logic [31:0]    r_pkt_seq, w_pkt_seq_nxt;
  logic [31:0]    r_exp_seq, w_exp_seq_nxt;
  logic           r_locked, r_tready, r_err_pulse;
  logic [BPW-1:0] r_bp_cnt, w_bp_nxt;
  logic           w_throttle;

  logic        w_acc, w_strb_bad, w_lock_set;
  logic        w_word_err, w_seq_err, w_good_close, w_bad_close;
  logic [31:0] w_rx_seq, w_rx_idx;
  logic [63:0] w_exp_word;

  // The throttle cycle lines up with the counter sitting at its last value.
  always_comb begin
    w_bp_nxt   = '0;
    w_throttle = 1'b0;
    if (C_BP_PERIOD > 0) begin
      if (32'(r_bp_cnt) != 32'(C_BP_PERIOD - 1)) begin
        w_bp_nxt = r_bp_cnt + BPW'(1);
      end
      w_throttle = (32'(w_bp_nxt) == 32'(C_BP_PERIOD - 1));
    end
  end

  assign w_acc      = s_axis_tvalid && r_tready;
  assign w_rx_seq   = s_axis_tdata[63:32];
  assign w_rx_idx   = s_axis_tdata[31:0];
  assign w_strb_bad = (s_axis_tstrb != STRB_ALL);
  assign w_exp_word = mk_word(r_pkt_seq, r_idx);

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_bad_nxt     = r_bad;
    w_pkt_seq_nxt = r_pkt_seq;
    w_exp_seq_nxt = r_exp_seq;
    w_lock_set    = 1'b0;
    w_word_err    = 1'b0;
    w_seq_err     = 1'b0;
    w_good_close  = 1'b0;
    w_bad_close   = 1'b0;
    if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          // Whether matched or resynced, the next packet is expected one above this one.
          w_word_err    = (w_rx_idx != 32'd0) || w_strb_bad;
          w_seq_err     = r_locked && (w_rx_seq != r_exp_seq);
          w_lock_set    = 1'b1;
          w_exp_seq_nxt = w_rx_seq + 32'd1;
          w_pkt_seq_nxt = w_rx_seq;
          if (s_axis_tlast) begin
            w_bad_close = 1'b1;
            w_bad_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_PKT;
            w_idx_nxt   = 32'd1;
            w_bad_nxt   = w_word_err || w_seq_err;
          end
        end
        S_PKT: begin
          w_word_err = (s_axis_tdata != w_exp_word) || w_strb_bad;
          if (s_axis_tlast) begin
            w_good_close = (r_idx == LAST_IDX) && !r_bad && !w_word_err;
            w_bad_close  = !w_good_close;
            w_state_nxt  = S_IDLE;
            w_idx_nxt    = 32'd0;
            w_bad_nxt    = 1'b0;
          end else if (r_idx == LAST_IDX) begin
            w_bad_close = 1'b1;
            w_state_nxt = S_DRAIN;
            w_idx_nxt   = 32'd0;
            w_bad_nxt   = 1'b0;
          end else begin
            w_idx_nxt = r_idx + 32'd1;
            w_bad_nxt = r_bad || w_word_err;
          end
        end
        S_DRAIN: begin
          if (s_axis_tlast) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_state     <= S_IDLE;
      r_idx       <= 32'd0;
      r_bad       <= 1'b0;
      r_pkt_seq   <= 32'd0;
      r_exp_seq   <= 32'd0;
      r_locked    <= 1'b0;
      r_tready    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_bp_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_bad       <= w_bad_nxt;
      r_pkt_seq   <= w_pkt_seq_nxt;
      r_exp_seq   <= w_exp_seq_nxt;
      r_tready    <= chk_enable && !w_throttle;
      r_err_pulse <= w_bad_close;
      r_bp_cnt    <= w_bp_nxt;
      if (clear_counters) begin
        r_locked <= 1'b0;
      end else if (w_lock_set) begin
        r_locked <= 1'b1;
      end
    end
  end

  sat_counter #(.W(C_CNT_WIDTH)) u_good_cnt (
    .clk(axi_aclk), .reset(axi_areset), .clr(clear_counters), .inc(w_good_close), .count(good_pkt_cnt)
  );
  sat_counter #(.W(C_CNT_WIDTH)) u_bad_cnt (
    .clk(axi_aclk), .reset(axi_areset), .clr(clear_counters), .inc(w_bad_close), .count(bad_pkt_cnt)
  );
  sat_counter #(.W(C_CNT_WIDTH)) u_word_err_cnt (
    .clk(axi_aclk), .reset(axi_areset), .clr(clear_counters), .inc(w_word_err), .count(word_err_cnt)
  );
  sat_counter #(.W(C_CNT_WIDTH)) u_seq_err_cnt (
    .clk(axi_aclk), .reset(axi_areset), .clr(clear_counters), .inc(w_seq_err), .count(seq_err_cnt)
  );

  assign s_axis_tready = r_tready;
  assign err_pulse     = r_err_pulse;
  assign locked        = r_locked;

endmodule
